// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Fetch-stage bundle: PC input, instruction-memory request/ack,
//            decode valid/ready handshake, flush and fault reporting.
// Revision : 1.0
// ============================================================================
interface fetch_if #(
    parameter int REG_BITS   = 32,
    parameter int INSTR_BITS = 32
);
    logic [REG_BITS-1:0]   pc_in;
    logic                  pc_advance;
    logic                  imem_req;
    logic [REG_BITS-1:0]   imem_addr;
    logic                  imem_ack;
    logic [INSTR_BITS-1:0] imem_rdata;
    logic [INSTR_BITS-1:0] instr_out;
    logic [REG_BITS-1:0]   instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  flush;
    logic                  fault;
    logic [1:0]            fault_code;

    // The fetch unit drives the master side.
    modport master (
        input  pc_in, imem_ack, imem_rdata, instr_ready, flush,
        output pc_advance, imem_req, imem_addr, instr_out, instr_pc,
               instr_valid, fault, fault_code
    );

    modport slave (
        output pc_in, imem_ack, imem_rdata, instr_ready, flush,
        input  pc_advance, imem_req, imem_addr, instr_out, instr_pc,
               instr_valid, fault, fault_code
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: samples the PC, reads instruction
//            memory, holds the word for decode and pulses pc_advance.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int REG_BITS   = 32,
    parameter int INSTR_BITS = 32,
    parameter int TIMEOUT    = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    fetch_if.master   bus
);
    localparam int                  CNT_BITS   = $clog2(TIMEOUT + 1);
    localparam logic [REG_BITS-1:0] ALIGN_MASK = (REG_BITS == 16) ? REG_BITS'(1) : REG_BITS'(3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_ADV   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  discard_q, discard_d;
    logic                  req_q, req_d;
    logic [REG_BITS-1:0]   addr_q, addr_d;
    logic [INSTR_BITS-1:0] instr_q, instr_d;
    logic [REG_BITS-1:0]   ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  adv_q, adv_d;
    logic                  fault_q, fault_d;
    logic [1:0]            code_q, code_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        req_d     = req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        adv_d     = 1'b0;
        fault_d   = fault_q;
        code_d    = code_q;
        case (state_q)
            S_IDLE: begin
                if (|(bus.pc_in & ALIGN_MASK)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = 2'b01;
                end else begin
                    addr_d  = bus.pc_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The request is never withdrawn; a flush only marks the reply for discard.
                if (bus.flush) discard_d = 1'b1;
                if (bus.imem_ack) begin
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    if (discard_q || bus.flush) begin
                        state_d = S_ADV;
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (cnt_q == CNT_BITS'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    fault_d   = 1'b1;
                    code_d    = 2'b10;
                    state_d   = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.flush) begin
                    valid_d = 1'b0;
                    state_d = S_ADV;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    adv_d   = 1'b1;
                    state_d = S_ADV;
                end
            end
            S_ADV:   state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
            adv_q     <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            adv_q     <= adv_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_advance  = adv_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench: directed cycle table, timeout sequence and
//            randomized traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst2;

    fetch_if #(.REG_BITS(32), .INSTR_BITS(32)) bus1 ();
    fetch_if #(.REG_BITS(32), .INSTR_BITS(32)) bus2 ();

    fetch_unit #(.REG_BITS(32), .INSTR_BITS(32), .TIMEOUT(6)) u_dut (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.master)
    );

    fetch_unit #(.REG_BITS(32), .INSTR_BITS(32), .TIMEOUT(3)) u_dut_to (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2.master)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        fl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_out;
        logic [31:0] e_ipc;
        logic        e_adv;
        logic        e_fault;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic void add(input logic rst, input logic [31:0] pc, input logic ack,
                                input logic [31:0] rd, input logic rdy, input logic fl,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] eo, input logic [31:0] ei,
                                input logic eadv, input logic ef, input logic [1:0] ec);
        vt.push_back('{rst, pc, ack, rd, rdy, fl, er, ea, ev, eo, ei, eadv, ef, ec});
    endfunction

    task automatic run_table();
        localparam logic [31:0] A = 32'h00500093;
        localparam logic [31:0] D = 32'hDEADBEEF;
        //  rst pc     ack rdata         rdy fl | req addr   val out           ipc    adv flt code
        add(1, 32'h00, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h00, 0, 32'h0,         0, 0,   1, 32'h00, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h00, 1, A,             0, 0,   0, 32'h00, 1, A,             32'h00, 0, 0, 2'd0);
        add(0, 32'h00, 0, 32'h0,         1, 0,   0, 32'h00, 0, A,             32'h00, 1, 0, 2'd0);
        add(0, 32'h10, 0, 32'h0,         0, 0,   0, 32'h00, 0, A,             32'h00, 0, 0, 2'd0);
        add(0, 32'h10, 0, 32'h0,         0, 0,   1, 32'h10, 0, A,             32'h00, 0, 0, 2'd0);
        add(0, 32'h10, 1, D,             0, 0,   0, 32'h10, 1, D,             32'h10, 0, 0, 2'd0);
        for (int k = 0; k < 5; k++)
            add(0, 32'h10, 0, 32'h0,     0, 0,   0, 32'h10, 1, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h20, 0, 32'h0,         1, 0,   0, 32'h10, 0, D,             32'h10, 1, 0, 2'd0);
        add(0, 32'h20, 0, 32'h0,         0, 0,   0, 32'h10, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h20, 0, 32'h0,         0, 0,   1, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h20, 0, 32'h0,         0, 0,   1, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 0, 32'h0,         0, 1,   1, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 0, 32'h0,         0, 0,   1, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 1, 32'h11111111,  0, 0,   0, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 0, 32'h0,         0, 0,   0, 32'h20, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 0, 32'h0,         0, 0,   1, 32'h80, 0, D,             32'h10, 0, 0, 2'd0);
        add(0, 32'h80, 1, 32'h22222222,  0, 0,   0, 32'h80, 1, 32'h22222222,  32'h80, 0, 0, 2'd0);
        add(0, 32'h80, 0, 32'h0,         1, 1,   0, 32'h80, 0, 32'h22222222,  32'h80, 0, 0, 2'd0);
        add(0, 32'h06, 0, 32'h0,         0, 0,   0, 32'h80, 0, 32'h22222222,  32'h80, 0, 0, 2'd0);
        add(0, 32'h06, 0, 32'h0,         0, 0,   0, 32'h80, 0, 32'h22222222,  32'h80, 0, 1, 2'd1);
        add(0, 32'h00, 1, 32'h12345678,  1, 1,   0, 32'h80, 0, 32'h22222222,  32'h80, 0, 1, 2'd1);
        add(0, 32'h00, 0, 32'h0,         0, 0,   0, 32'h80, 0, 32'h22222222,  32'h80, 0, 1, 2'd1);
        add(1, 32'h00, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h40, 0, 32'h0,         0, 0,   1, 32'h40, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h40, 0, 32'h0,         0, 0,   1, 32'h40, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(1, 32'h44, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h44, 1, 32'h33333333,  0, 0,   1, 32'h44, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h44, 0, 32'h0,         0, 0,   1, 32'h44, 0, 32'h0,         32'h00, 0, 0, 2'd0);
        add(0, 32'h44, 1, 32'h44444444,  0, 0,   0, 32'h44, 1, 32'h44444444,  32'h44, 0, 0, 2'd0);
        add(0, 32'h48, 0, 32'h0,         1, 0,   0, 32'h44, 0, 32'h44444444,  32'h44, 1, 0, 2'd0);
        add(0, 32'h48, 0, 32'h0,         0, 0,   0, 32'h44, 0, 32'h44444444,  32'h44, 0, 0, 2'd0);

        for (int i = 0; i < vt.size(); i++) begin
            rst1             = vt[i].rst;
            bus1.pc_in       = vt[i].pc;
            bus1.imem_ack    = vt[i].ack;
            bus1.imem_rdata  = vt[i].rdata;
            bus1.instr_ready = vt[i].rdy;
            bus1.flush       = vt[i].fl;
            tick();
            check($sformatf("row%0d_req", i),   32'(bus1.imem_req),    32'(vt[i].e_req));
            check($sformatf("row%0d_valid", i), 32'(bus1.instr_valid), 32'(vt[i].e_valid));
            check($sformatf("row%0d_adv", i),   32'(bus1.pc_advance),  32'(vt[i].e_adv));
            check($sformatf("row%0d_fault", i), 32'(bus1.fault),       32'(vt[i].e_fault));
            check($sformatf("row%0d_code", i),  32'(bus1.fault_code),  32'(vt[i].e_code));
            check($sformatf("row%0d_out", i),   bus1.instr_out,        vt[i].e_out);
            check($sformatf("row%0d_ipc", i),   bus1.instr_pc,         vt[i].e_ipc);
            if (vt[i].e_req || vt[i].rst)
                check($sformatf("row%0d_addr", i), bus1.imem_addr, vt[i].e_addr);
        end
    endtask

    task automatic run_timeout();
        int hi = 0;
        rst2             = 1'b1;
        bus2.pc_in       = 32'h40;
        bus2.imem_ack    = 1'b0;
        bus2.imem_rdata  = 32'h0;
        bus2.instr_ready = 1'b0;
        bus2.flush       = 1'b0;
        tick();
        check("to_reset_req",   32'(bus2.imem_req), 32'd0);
        check("to_reset_fault", 32'(bus2.fault),    32'd0);
        rst2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus2.imem_rdata = $urandom;
            tick();
            if (bus2.imem_req) hi++;
        end
        check("to_req_cycles", 32'(hi),              32'd3);
        check("to_req_low",    32'(bus2.imem_req),   32'd0);
        check("to_fault",      32'(bus2.fault),      32'd1);
        check("to_code",       32'(bus2.fault_code), 32'd2);
        check("to_valid",      32'(bus2.instr_valid), 32'd0);
    endtask

    // Randomized traffic: the bench plays PC register, memory and decode,
    // and checks each observable transaction rather than the cycle schedule.
    task automatic run_random(input int cycles);
        logic [31:0] pc_reg, prev_pc, req_addr, pre_out, pre_ipc;
        logic        pre_req, pre_ack, pre_valid, pre_ready, pre_flush, req_flushed, fl;
        int          lat, accepts;
        rst1 = 1'b1;
        bus1.imem_ack = 1'b0; bus1.flush = 1'b0; bus1.instr_ready = 1'b0;
        tick();
        rst1        = 1'b0;
        pc_reg      = 32'h100;
        bus1.pc_in  = pc_reg;
        lat         = -1;
        req_flushed = 1'b0;
        req_addr    = '0;
        accepts     = 0;
        for (int c = 0; c < cycles; c++) begin
            prev_pc = bus1.pc_in;
            fl      = ($urandom_range(0, 9) == 0);
            if (bus1.pc_advance) pc_reg = pc_reg + 32'd4;
            if (fl) pc_reg = 32'($urandom_range(0, 1023)) << 2;
            bus1.pc_in       = pc_reg;
            bus1.flush       = fl;
            bus1.instr_ready = ($urandom_range(0, 2) != 0);
            if (bus1.imem_req) begin
                if (lat < 0) begin
                    req_addr = bus1.imem_addr;
                    check("rnd_req_addr", bus1.imem_addr, prev_pc);
                    lat = $urandom_range(0, 4);
                end
                if (fl) req_flushed = 1'b1;
                bus1.imem_ack = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                bus1.imem_ack = ($urandom_range(0, 3) == 0);
            end
            bus1.imem_rdata = (bus1.imem_ack && bus1.imem_req) ? mem_word(req_addr) : $urandom;

            pre_req   = bus1.imem_req;
            pre_ack   = bus1.imem_ack;
            pre_valid = bus1.instr_valid;
            pre_ready = bus1.instr_ready;
            pre_flush = fl;
            pre_out   = bus1.instr_out;
            pre_ipc   = bus1.instr_pc;
            tick();

            if (pre_req && !pre_ack) begin
                check("rnd_req_held", 32'(bus1.imem_req), 32'd1);
                check("rnd_addr_held", bus1.imem_addr, req_addr);
            end
            if (pre_req && pre_ack) begin
                check("rnd_req_drop", 32'(bus1.imem_req), 32'd0);
                if (req_flushed) begin
                    check("rnd_discard", 32'(bus1.instr_valid), 32'd0);
                end else begin
                    check("rnd_capture_valid", 32'(bus1.instr_valid), 32'd1);
                    check("rnd_capture_data",  bus1.instr_out, mem_word(req_addr));
                    check("rnd_capture_pc",    bus1.instr_pc,  req_addr);
                end
                req_flushed = 1'b0;
                lat         = -1;
            end
            if (pre_valid && !pre_flush && !pre_ready) begin
                check("rnd_hold_valid", 32'(bus1.instr_valid), 32'd1);
                check("rnd_hold_out",   bus1.instr_out, pre_out);
                check("rnd_hold_pc",    bus1.instr_pc,  pre_ipc);
            end
            if (pre_valid && (pre_flush || pre_ready))
                check("rnd_release", 32'(bus1.instr_valid), 32'd0);
            if (pre_valid && pre_ready && !pre_flush) accepts++;
            check("rnd_adv", 32'(bus1.pc_advance), 32'(pre_valid && pre_ready && !pre_flush));
            check("rnd_fault", 32'(bus1.fault), 32'd0);
        end
        check("rnd_progress", 32'(accepts > 50), 32'd1);
    endtask

    initial begin
        rst1             = 1'b1;
        rst2             = 1'b1;
        bus1.pc_in       = '0;
        bus1.imem_ack    = 1'b0;
        bus1.imem_rdata  = '0;
        bus1.instr_ready = 1'b0;
        bus1.flush       = 1'b0;
        bus2.pc_in       = '0;
        bus2.imem_ack    = 1'b0;
        bus2.imem_rdata  = '0;
        bus2.instr_ready = 1'b0;
        bus2.flush       = 1'b0;
        run_table();
        run_timeout();
        run_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
